// File: rtl/hub75_capture.sv
// HUB75 panel-side capture: decodes led_matrix bit-planes into a {half,row,col} pixel RAM read over Wishbone.
// Define HUB75_CAP_STATS_EN to add the status word (frame count, OE-low time, overflow) above the pixel RAM.
module hub75_capture #(
    parameter int COL = 32,
    parameter int ROW = 16,
    localparam int CW = $clog2(COL),
    localparam int RW = $clog2(ROW / 2),
    localparam int AW = 1 + RW + CW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          bus_cyc,
    input  logic          bus_stb,
    input  logic          bus_we,
    input  logic [AW:0]   bus_adr,
    output logic [31:0]   bus_dat,
    output logic          bus_ack,
    output logic          bus_err,
    input  logic [2:0]    hub_rgb0,
    input  logic [2:0]    hub_rgb1,
    input  logic          hub_clk,
    input  logic          hub_stb,
    input  logic          hub_oe_n,
    input  logic [RW-1:0] hub_row,
    output logic [1:0]    wr_state
);

    localparam logic [CW:0] COL_N = (CW + 1)'(COL);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_TOP = 2'd1, W_BOT = 2'd2} w_state_t;

    logic [2:0]    rgb0_s1, rgb0_s2, rgb1_s1, rgb1_s2;
    logic [RW-1:0] row_s1, row_s2;
    logic [2:0]    clk_s, stb_s;
    logic          shift_ev, latch_ev;

    // [0],[1] are the synchroniser, [2] is the edge-detect stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb0_s1 <= '0;
            rgb0_s2 <= '0;
            rgb1_s1 <= '0;
            rgb1_s2 <= '0;
            row_s1  <= '0;
            row_s2  <= '0;
            clk_s   <= '0;
            stb_s   <= '0;
        end else begin
            rgb0_s1 <= hub_rgb0;
            rgb0_s2 <= rgb0_s1;
            rgb1_s1 <= hub_rgb1;
            rgb1_s2 <= rgb1_s1;
            row_s1  <= hub_row;
            row_s2  <= row_s1;
            clk_s   <= {clk_s[1:0], hub_clk};
            stb_s   <= {stb_s[1:0], hub_stb};
        end
    end

    assign shift_ev = clk_s[1] & ~clk_s[2];
    assign latch_ev = stb_s[1] & ~stb_s[2];

    logic [CW:0]   col_cnt;
    logic [2:0]    last_plane, exp_plane;
    logic [RW-1:0] last_row;
    logic          row_valid;
    logic          overflow;
    logic          stat_clr;
    logic [CW-1:0] ci;
    logic          shift_ok;

    assign exp_plane = (!row_valid || row_s2 != last_row) ? 3'd7 : last_plane - 3'd1;
    assign ci        = col_cnt[CW-1:0];
    assign shift_ok  = shift_ev & ~latch_ev & (col_cnt != COL_N);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_cnt    <= '0;
            last_plane <= '0;
            last_row   <= '0;
            row_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (stat_clr) overflow <= 1'b0;
            if (latch_ev) begin
                col_cnt    <= '0;
                last_row   <= row_s2;
                last_plane <= exp_plane;
                row_valid  <= 1'b1;
                if (shift_ev) overflow <= 1'b1;
            end else if (shift_ev) begin
                if (col_cnt == COL_N) overflow <= 1'b1;
                else col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Planes 7..1 per column; bit p-1 holds plane p, plane 0 goes straight to the RAM word
    logic [6:0] acc_tr [COL];
    logic [6:0] acc_tg [COL];
    logic [6:0] acc_tb [COL];
    logic [6:0] acc_br [COL];
    logic [6:0] acc_bg [COL];
    logic [6:0] acc_bb [COL];
    logic [2:0] pi;

    assign pi = exp_plane - 3'd1;

    always_ff @(posedge clk_i) begin
        if (shift_ok && exp_plane != 3'd0) begin
            acc_tr[ci][pi] <= rgb0_s2[2];
            acc_tg[ci][pi] <= rgb0_s2[1];
            acc_tb[ci][pi] <= rgb0_s2[0];
            acc_br[ci][pi] <= rgb1_s2[2];
            acc_bg[ci][pi] <= rgb1_s2[1];
            acc_bb[ci][pi] <= rgb1_s2[0];
        end
    end

    w_state_t      state;
    logic          wr_en;
    logic [AW-1:0] wr_adr;
    logic [23:0]   wr_dat;
    logic [CW-1:0] wr_col;
    logic [RW-1:0] wr_row;
    logic [2:0]    bit0_bot;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= W_IDLE;
            wr_en    <= 1'b0;
            wr_adr   <= '0;
            wr_dat   <= '0;
            wr_col   <= '0;
            wr_row   <= '0;
            bit0_bot <= '0;
        end else begin
            case (state)
                W_IDLE: begin
                    wr_en <= 1'b0;
                    if (shift_ok && exp_plane == 3'd0) begin
                        wr_col   <= ci;
                        wr_row   <= row_s2;
                        bit0_bot <= rgb1_s2;
                        wr_en    <= 1'b1;
                        wr_adr   <= {1'b0, row_s2, ci};
                        wr_dat   <= {acc_tr[ci], rgb0_s2[2], acc_tg[ci], rgb0_s2[1],
                                     acc_tb[ci], rgb0_s2[0]};
                        state    <= W_TOP;
                    end
                end
                W_TOP: begin
                    wr_en  <= 1'b1;
                    wr_adr <= {1'b1, wr_row, wr_col};
                    wr_dat <= {acc_br[wr_col], bit0_bot[2], acc_bg[wr_col], bit0_bot[1],
                               acc_bb[wr_col], bit0_bot[0]};
                    state  <= W_BOT;
                end
                W_BOT: begin
                    wr_en <= 1'b0;
                    state <= W_IDLE;
                end
                default: begin
                    wr_en <= 1'b0;
                    state <= W_IDLE;
                end
            endcase
        end
    end

    assign wr_state = state;

    // Wishbone: take is the first cycle of a select; ack follows one cycle later for one cycle
    logic        sel, take, hi_q;
    logic [23:0] ram [2**AW];
    logic [23:0] ram_q;
    logic [31:0] hi_word;

    assign sel  = bus_cyc & bus_stb;
    assign take = sel & ~bus_ack;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_ack <= 1'b0;
            hi_q    <= 1'b0;
        end else begin
            bus_ack <= take;
            if (take) hi_q <= bus_adr[AW];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) ram[wr_adr] <= wr_dat;
        if (take) ram_q <= ram[bus_adr[AW-1:0]];
    end

    assign bus_dat = hi_q ? hi_word : {8'h0, ram_q};
    assign bus_err = 1'b0;

`ifdef HUB75_CAP_STATS_EN
    localparam logic [AW:0]   STAT_ADR = {1'b1, {AW{1'b0}}};
    localparam logic [RW-1:0] LAST_ROW = RW'(ROW / 2 - 1);

    logic [1:0]  oe_s;
    logic [15:0] frame_cnt;
    logic [14:0] on_cnt;
    logic [31:0] stat_q;
    logic        stat_hit_q;
    logic        stat_rd;

    assign stat_rd  = take & (bus_adr == STAT_ADR);
    assign stat_clr = stat_rd & ~bus_we;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oe_s       <= 2'b11;
            frame_cnt  <= '0;
            on_cnt     <= '0;
            stat_q     <= '0;
            stat_hit_q <= 1'b0;
        end else begin
            oe_s <= {oe_s[0], hub_oe_n};
            if (latch_ev) on_cnt <= '0;
            else if (!oe_s[1] && on_cnt != 15'h7FFF) on_cnt <= on_cnt + 15'd1;
            if (latch_ev && exp_plane == 3'd0 && row_s2 == LAST_ROW) frame_cnt <= frame_cnt + 16'd1;
            if (take) stat_hit_q <= (bus_adr == STAT_ADR);
            if (stat_rd) stat_q <= {frame_cnt, on_cnt, overflow};
        end
    end

    assign hi_word = stat_hit_q ? stat_q : 32'h0;
`else
    logic unused_stats;
    assign unused_stats = ^{hub_oe_n, bus_we, overflow};
    assign stat_clr     = 1'b0;
    assign hi_word      = 32'h0;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// Bench for hub75_capture: drives led_matrix-style bit-plane rows and reads the pixel RAM back over Wishbone.
// Expectations follow HUB75_CAP_STATS_EN the same way the design does.
module tb_hub75_capture;

    localparam int COL = 32;
    localparam int ROW = 16;
    localparam int NW  = 2 * (ROW / 2) * COL;

`ifdef HUB75_CAP_STATS_EN
    localparam logic [31:0] STAT_MASK = 32'hFFFF_0001;
`else
    localparam logic [31:0] STAT_MASK = 32'hFFFF_FFFF;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        bus_cyc = 1'b0, bus_stb = 1'b0, bus_we = 1'b0;
    logic [9:0]  bus_adr = '0;
    logic [31:0] bus_dat;
    logic        bus_ack, bus_err;
    logic [2:0]  hub_rgb0 = '0, hub_rgb1 = '0;
    logic        hub_clk = 1'b0, hub_stb = 1'b0, hub_oe_n = 1'b1;
    logic [2:0]  hub_row = '0;
    logic [1:0]  wr_state;

    hub75_capture #(.COL(COL), .ROW(ROW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr),
        .bus_dat(bus_dat), .bus_ack(bus_ack), .bus_err(bus_err),
        .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1), .hub_clk(hub_clk), .hub_stb(hub_stb),
        .hub_oe_n(hub_oe_n), .hub_row(hub_row), .wr_state(wr_state)
    );

    // clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [23:0] model [NW];
    logic [23:0] top_px [COL];
    logic [23:0] bot_px [COL];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    function automatic logic [2:0] plane_bits(input logic [23:0] w, input int p);
        return {w[16+p], w[8+p], w[p]};
    endfunction

    function automatic int adr_of(input int half, input int row, input int col);
        return half * (ROW / 2) * COL + row * COL + col;
    endfunction

    // Wishbone driver: the expected read word is queued before the request, popped at ack
    task automatic wb_xfer(input logic we, input int adr, input logic [31:0] exp,
                           input logic [31:0] mask, input bit timing);
        int n;
        bit got;
        if (!we) exp_q.push_back(exp & mask);
        bus_adr = 10'(adr);
        bus_we  = we;
        bus_cyc = 1'b1;
        bus_stb = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(posedge clk_i);
            #1;
            n++;
            if (bus_ack) got = 1'b1;
        end
        check("ack_seen", 32'(got), 32'd1);
        if (got) begin
            if (timing) check("ack_latency", n, 1);
            check("bus_err", 32'(bus_err), 32'd0);
            if (!we) check($sformatf("rd_%0d", adr), bus_dat & mask, exp_q.pop_front());
        end else if (!we) begin
            void'(exp_q.pop_front());
        end
        bus_cyc = 1'b0;
        bus_stb = 1'b0;
        bus_we  = 1'b0;
        if (timing) begin
            tick(1);
            check("ack_pulse", 32'(bus_ack), 32'd0);
        end
    endtask

    task automatic rd_pixel(input int adr);
        wb_xfer(1'b0, adr, {8'h0, model[adr]}, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic rd_status(input int frames, input bit ovf);
`ifdef HUB75_CAP_STATS_EN
        wb_xfer(1'b0, NW, {16'(frames), 15'h0, ovf}, STAT_MASK, 1'b0);
`else
        wb_xfer(1'b0, NW, 32'(frames & 0) | 32'(ovf & 1'b0), STAT_MASK, 1'b0);
`endif
    endtask

    // HUB75 pin drivers: every phase is 2 clk_i cycles
    task automatic hub_shift(input logic [2:0] t, input logic [2:0] b);
        hub_rgb0 = t;
        hub_rgb1 = b;
        tick(2);
        hub_clk = 1'b1;
        tick(2);
        hub_clk = 1'b0;
    endtask

    task automatic hub_latch();
        tick(2);
        hub_stb = 1'b1;
        tick(2);
        hub_stb = 1'b0;
    endtask

    task automatic send_row(input int row, input int first_p, input int last_p, input bit extra);
        hub_row = 3'(row);
        for (int p = first_p; p >= last_p; p--) begin
            for (int c = 0; c < COL; c++) hub_shift(plane_bits(top_px[c], p), plane_bits(bot_px[c], p));
            if (extra && p == 7) hub_shift(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            hub_latch();
        end
        tick(4);
    endtask

    task automatic commit_row(input int row);
        for (int c = 0; c < COL; c++) begin
            model[adr_of(0, row, c)] = top_px[c];
            model[adr_of(1, row, c)] = bot_px[c];
        end
    endtask

    task automatic random_row();
        for (int c = 0; c < COL; c++) begin
            top_px[c] = 24'($urandom_range(0, 32'h00FF_FFFF));
            bot_px[c] = 24'($urandom_range(0, 32'h00FF_FFFF));
        end
    endtask

    task automatic check_row(input int row);
        for (int c = 0; c < COL; c++) begin
            rd_pixel(adr_of(0, row, c));
            rd_pixel(adr_of(1, row, c));
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick(2);
        rst_i = 1'b0;
        tick(1);
    endtask

    initial begin
        #1;
        // 1: reset and bus handshake
        do_reset();
        check("ack_after_reset", 32'(bus_ack), 32'd0);
        check("wr_state_reset", 32'(wr_state), 32'd0);
        wb_xfer(1'b0, NW, 32'h0, STAT_MASK, 1'b1);
        wb_xfer(1'b0, NW + 1, 32'h0, 32'hFFFF_FFFF, 1'b1);
        wb_xfer(1'b1, 7, 32'h0, 32'h0, 1'b1);

        // 2: one row, all planes, with the known pixel at column 5
        random_row();
        top_px[5] = 24'hA5_3C_0F;
        bot_px[5] = 24'h01_80_FF;
        send_row(3, 7, 0, 1'b0);
        commit_row(3);
        wb_xfer(1'b0, adr_of(0, 3, 5), 32'h00A5_3C0F, 32'hFFFF_FFFF, 1'b1);
        wb_xfer(1'b0, adr_of(1, 3, 5), 32'h0001_80FF, 32'hFFFF_FFFF, 1'b1);
        check_row(3);

        // 3: 33 shifts on plane 7 of row 0; the extra column is dropped
        random_row();
        send_row(0, 7, 0, 1'b1);
        commit_row(0);
        check_row(0);
        rd_status(0, 1'b1);
        rd_status(0, 1'b0);

        // 4: two full frames, the second is the first plus one per pixel
        for (int r = 0; r < ROW / 2; r++) begin
            random_row();
            send_row(r, 7, 0, 1'b0);
            commit_row(r);
        end
        for (int r = 0; r < ROW / 2; r++) begin
            for (int c = 0; c < COL; c++) begin
                top_px[c] = model[adr_of(0, r, c)] + 24'd1;
                bot_px[c] = model[adr_of(1, r, c)] + 24'd1;
            end
            send_row(r, 7, 0, 1'b0);
            commit_row(r);
        end
        for (int a = 0; a < NW; a++) rd_pixel(a);
        rd_status(2, 1'b0);

        // 5: reset after plane 4 of row 2, then row 2 resent from plane 7
        random_row();
        send_row(2, 7, 4, 1'b0);
        do_reset();
        check("wr_state_mid_reset", 32'(wr_state), 32'd0);
        send_row(2, 7, 0, 1'b0);
        commit_row(2);
        check_row(2);
        check_row(1);

        // 6: shift and latch rising together on row 5; latch wins, next planes start at col 0
        random_row();
        send_row(5, 7, 0, 1'b0);
        commit_row(5);
        hub_rgb0 = 3'b111;
        hub_rgb1 = 3'b111;
        tick(2);
        hub_clk = 1'b1;
        hub_stb = 1'b1;
        tick(2);
        hub_clk = 1'b0;
        hub_stb = 1'b0;
        for (int c = 0; c < COL; c++) begin
            top_px[c] = top_px[c] ^ 24'h7F_7F7F;
            bot_px[c] = bot_px[c] ^ 24'h7F_7F7F;
        end
        send_row(5, 6, 0, 1'b0);
        commit_row(5);
        check_row(5);
        rd_status(0, 1'b1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
